sd_cmd_sender: RTL and testbench
================================

Name: sd_cmd_sender

Overview:
- Upstream command stage for the SPI byte shifter in the SD-card test path.
- Takes an SD command index and 32-bit argument, builds the 6-byte SPI-mode command frame with CRC7, and streams it byte by byte to the shifter.
- Then clocks out fill bytes until an R1 response arrives or the NCR limit expires.
- Reports R1, done and timeout to the controlling sequencer.

Parameters:
- NCR_MAX, 8: maximum number of poll bytes after the CRC byte before declaring timeout (1..255).
- FILL_BYTE, 8'hFF: byte value transmitted while polling.

Ports:
- clock  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-clock request; sampled only in IDLE.
- cmd_index  input  6  SD command number; captured on accepted start.
- cmd_arg  input  32  command argument; captured on accepted start.
- busy  output  1  high from accepted start until the cycle after done.
- done  output  1  one-clock pulse when the command completes or times out.
- timeout  output  1  valid with done; 1 = no R1 within NCR_MAX poll bytes; held until next start.
- r1  output  8  captured R1 byte; 8'hFF on timeout; held until next start.
- cs_n  output  1  SD chip select, active low; low from SEND entry to DONE.
- tx_valid  output  1  byte-available to shifter.
- tx_byte  output  8  byte to shift out.
- rx_byte  input  8  byte received by shifter; valid when byte_done is high.
- byte_done  input  1  one-clock pulse from shifter at each byte boundary.
- spi_idle  input  1  shifter idle (no byte in flight).

Behaviour:
- Reset (async), values: busy=0, done=0, timeout=0, r1=8'hFF, cs_n=1, tx_valid=0, tx_byte=8'hFF; state IDLE; counters 0.
- Frame: F[47:0] = {2'b01, cmd_index, cmd_arg, crc7, 1'b1}, sent MSB byte first (bytes F[47:40] .. F[7:0]).
- CRC7: polynomial x^7+x^3+1, register init 0, over F[47:8] MSB first.
- IDLE:
  - start=1 latches cmd_index/cmd_arg, clears timeout, sets busy; next state CRC.
  - start in any other state is ignored.
- CRC:
  - One message bit per clock, exactly 40 clocks; then WAIT_IDLE.
  - crc7 is not valid before 40 clocks; no output changes in this state.
- WAIT_IDLE:
  - When spi_idle=1: drive cs_n=0, tx_valid=1, tx_byte=byte 0; go SEND.
- SEND:
  - Byte counter 0..5.
  - On each byte_done with counter<5: tx_byte <= next frame byte, counter++.
  - On byte_done with counter=5: tx_byte <= FILL_BYTE, poll counter=0; go POLL.
  - tx_valid stays 1 throughout; rx_byte is ignored in SEND.
- POLL:
  - Each byte_done is a poll byte; poll counter++.
  - rx_byte[7]==0: r1<=rx_byte, tx_valid<=0, go DONE.
  - Else if poll counter reaches NCR_MAX: r1<=8'hFF, timeout<=1, tx_valid<=0, go DONE.
  - The byte completing with the CRC byte is not a poll byte.
- DONE:
  - done=1 for one clock, cs_n<=1; go IDLE; busy drops the following cycle.
- byte_done outside SEND/POLL is ignored.
- Reset mid-command aborts immediately to reset values; no done pulse.

Test Plan:
- CMD0, arg 0: tx stream 40 00 00 00 00 95, then FF; rx FF then 01 -> done after 2 poll bytes, r1=8'h01, timeout=0, cs_n back to 1.
- CMD8, arg 32'h000001AA: tx bytes 48 00 00 01 AA 87; rx 01 on first poll byte -> r1=8'h01, exactly 7 byte_done pulses total.
- Timeout: rx always FF, NCR_MAX=8 -> 6 frame + 8 poll bytes; done with timeout=1, r1=8'hFF; tx_valid=0 after the 14th byte_done.
- Start during SEND with different index: ignored; the frame in flight is unchanged; no second done pulse.
- Reset asserted on 3rd byte of CMD17 -> all outputs at reset values within the same cycle, no done; then a new CMD0 completes normally.
- spi_idle held 0 for 20 clocks after CRC -> tx_valid stays 0 and cs_n stays 1 until spi_idle=1, then byte 0x40 is presented.

Source files
------------

// File: rtl/sd_cmd_sender.sv
// sd_cmd_sender: builds an SPI-mode SD command frame with CRC7,
// streams it to the byte shifter and polls for the R1 response.
module sd_cmd_sender #(
    parameter int unsigned NCR_MAX   = 8,
    parameter logic [7:0]  FILL_BYTE = 8'hFF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [7:0]  r1,
    output logic        cs_n,
    output logic        tx_valid,
    output logic [7:0]  tx_byte,
    input  logic [7:0]  rx_byte,
    input  logic        byte_done,
    input  logic        spi_idle
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CRC,
        S_WAIT_IDLE,
        S_SEND,
        S_POLL,
        S_DONE
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [5:0]  idx_q;
    logic [31:0] arg_q;
    logic [39:0] sh_q;
    logic [6:0]  crc_q;
    logic [5:0]  bit_cnt;
    logic [2:0]  byte_cnt;
    logic [7:0]  poll_cnt;
    logic [7:0]  poll_nx;
    logic [47:0] frame;
    logic [7:0]  next_byte;
    logic        crc_fb;
    logic        poll_end;

    assign frame    = {2'b01, idx_q, arg_q, crc_q, 1'b1};
    assign crc_fb   = sh_q[39] ^ crc_q[6];
    assign poll_nx  = poll_cnt + 8'd1;
    assign poll_end = !rx_byte[7] || (poll_nx == 8'(NCR_MAX));
    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DONE);

    // frame byte that follows byte number byte_cnt
    always_comb begin
        next_byte = frame[7:0];
        unique case (byte_cnt)
            3'd0:    next_byte = frame[39:32];
            3'd1:    next_byte = frame[31:24];
            3'd2:    next_byte = frame[23:16];
            3'd3:    next_byte = frame[15:8];
            default: next_byte = frame[7:0];
        endcase
    end

    // state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    // next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:      if (start) state_nx = S_CRC;
            S_CRC:       if (bit_cnt == 6'd39) state_nx = S_WAIT_IDLE;
            S_WAIT_IDLE: if (spi_idle) state_nx = S_SEND;
            S_SEND:      if (byte_done && byte_cnt == 3'd5) state_nx = S_POLL;
            S_POLL:      if (byte_done && poll_end) state_nx = S_DONE;
            S_DONE:      state_nx = S_IDLE;
            default:     state_nx = S_IDLE;
        endcase
    end

    // datapath: capture, serial CRC7, byte streaming and R1 capture
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idx_q    <= '0;
            arg_q    <= '0;
            sh_q     <= '0;
            crc_q    <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            poll_cnt <= '0;
            timeout  <= 1'b0;
            r1       <= 8'hFF;
            cs_n     <= 1'b1;
            tx_valid <= 1'b0;
            tx_byte  <= 8'hFF;
        end else begin
            unique case (state)
                S_IDLE: if (start) begin
                    idx_q   <= cmd_index;
                    arg_q   <= cmd_arg;
                    sh_q    <= {2'b01, cmd_index, cmd_arg};
                    crc_q   <= '0;
                    bit_cnt <= '0;
                    timeout <= 1'b0;
                    r1      <= 8'hFF;
                end
                S_CRC: begin
                    sh_q    <= {sh_q[38:0], 1'b0};
                    crc_q   <= {crc_q[5:0], 1'b0} ^ (crc_fb ? 7'h09 : 7'h00);
                    bit_cnt <= bit_cnt + 6'd1;
                end
                S_WAIT_IDLE: if (spi_idle) begin
                    cs_n     <= 1'b0;
                    tx_valid <= 1'b1;
                    tx_byte  <= frame[47:40];
                    byte_cnt <= '0;
                end
                S_SEND: if (byte_done) begin
                    if (byte_cnt == 3'd5) begin
                        tx_byte  <= FILL_BYTE;
                        poll_cnt <= '0;
                    end else begin
                        tx_byte  <= next_byte;
                        byte_cnt <= byte_cnt + 3'd1;
                    end
                end
                S_POLL: if (byte_done) begin
                    poll_cnt <= poll_nx;
                    if (!rx_byte[7]) begin
                        r1       <= rx_byte;
                        tx_valid <= 1'b0;
                    end else if (poll_nx == 8'(NCR_MAX)) begin
                        r1       <= 8'hFF;
                        timeout  <= 1'b1;
                        tx_valid <= 1'b0;
                    end
                end
                S_DONE:  cs_n <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_cmd_sender.sv
// tb_sd_cmd_sender: random and directed SD command frames checked
// against a polynomial-division CRC7 model and an R1 poll model.
module tb_sd_cmd_sender;

    localparam int NCR = 8;
    localparam logic [7:0] FILL = 8'hFF;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  cmd_index = '0;
    logic [31:0] cmd_arg = '0;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [7:0]  r1;
    logic        cs_n;
    logic        tx_valid;
    logic [7:0]  tx_byte;
    logic [7:0]  rx_byte = 8'hFF;
    logic        byte_done = 1'b0;
    logic        spi_idle = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;

    sd_cmd_sender #(.NCR_MAX(NCR), .FILL_BYTE(FILL)) dut (
        .clock(clock), .reset(reset), .start(start),
        .cmd_index(cmd_index), .cmd_arg(cmd_arg),
        .busy(busy), .done(done), .timeout(timeout), .r1(r1),
        .cs_n(cs_n), .tx_valid(tx_valid), .tx_byte(tx_byte),
        .rx_byte(rx_byte), .byte_done(byte_done), .spi_idle(spi_idle)
    );

    always #5 clock = ~clock;

    always @(posedge clock) if (done) done_cnt++;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // remainder of M(x)*x^7 divided by x^7+x^3+1 (0x89)
    function automatic logic [47:0] ref_frame(input logic [5:0] i,
                                              input logic [31:0] a);
        logic [46:0] r;
        r = {2'b01, i, a, 7'b0};
        for (int b = 46; b >= 7; b--)
            if (r[b]) r = r ^ (47'h89 << (b - 7));
        return {2'b01, i, a, r[6:0], 1'b1};
    endfunction

    task automatic check_reset_vals(input string tag);
        check(tag, {busy, done, timeout, r1, cs_n, tx_valid, tx_byte},
              {1'b0, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0, 8'hFF});
    endtask

    // resp_at: poll byte index carrying R1 (-1 = never)
    task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg,
                           input int resp_at, input logic [7:0] r1v,
                           input int idle_hold, input bit poke);
        logic [47:0] f;
        logic [7:0]  eb;
        int  n_poll;
        bit  to;
        int  dc0;
        int  k;
        int  bad;
        f   = ref_frame(idx, arg);
        to  = !(resp_at >= 0 && resp_at < NCR);
        n_poll = to ? NCR : resp_at + 1;
        dc0 = done_cnt;
        k   = 0;
        bad = 0;
        spi_idle  = (idle_hold == 0);
        start     = 1'b1;
        cmd_index = idx;
        cmd_arg   = arg;
        @(negedge clock);
        start     = 1'b0;
        cmd_index = 6'($urandom);
        cmd_arg   = $urandom;
        check("busy_start", busy, 1);
        for (int c = 0; c < idle_hold; c++) begin
            @(negedge clock);
            if (tx_valid || !cs_n) bad++;
        end
        check("idle_hold", bad, 0);
        spi_idle = 1'b1;
        for (int c = 0; c < 100 && !tx_valid; c++) @(negedge clock);
        check("tx_valid_on", tx_valid, 1);
        check("cs_n_low", cs_n, 0);
        while (!done && k < 40) begin
            repeat (2) @(negedge clock);
            eb = (k < 6) ? f[47 - 8*k -: 8] : FILL;
            check($sformatf("tx_byte%0d", k), tx_byte, eb);
            check("tx_valid_hold", tx_valid, 1);
            if (k < 6)
                rx_byte = 8'($urandom);
            else if (k - 6 == resp_at)
                rx_byte = r1v;
            else
                rx_byte = 8'h80 | 8'($urandom);
            if (poke && k == 2) begin
                start     = 1'b1;
                cmd_index = idx ^ 6'h15;
            end
            byte_done = 1'b1;
            @(negedge clock);
            byte_done = 1'b0;
            start     = 1'b0;
            k++;
        end
        check("done", done, 1);
        check("n_bytes", k, 6 + n_poll);
        check("r1", r1, to ? 8'hFF : r1v);
        check("timeout", timeout, to);
        check("tx_valid_off", tx_valid, 0);
        @(negedge clock);
        check("done_pulse", done, 0);
        check("cs_n_high", cs_n, 1);
        check("busy_drop", busy, 0);
        repeat (5) @(negedge clock);
        check("done_count", done_cnt - dc0, 1);
        check("r1_hold", r1, to ? 8'hFF : r1v);
        check("timeout_hold", timeout, to);
    endtask

    task automatic reset_mid(input logic [5:0] idx, input logic [31:0] arg);
        int dc0;
        dc0 = done_cnt;
        spi_idle  = 1'b1;
        start     = 1'b1;
        cmd_index = idx;
        cmd_arg   = arg;
        @(negedge clock);
        start = 1'b0;
        for (int c = 0; c < 100 && !tx_valid; c++) @(negedge clock);
        check("rm_tx_valid", tx_valid, 1);
        for (int k = 0; k < 2; k++) begin
            repeat (2) @(negedge clock);
            byte_done = 1'b1;
            @(negedge clock);
            byte_done = 1'b0;
        end
        @(negedge clock);
        reset = 1'b1;
        #1;
        check_reset_vals("rm_reset_vals");
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check_reset_vals("rm_after");
        check("rm_no_done", done_cnt - dc0, 0);
    endtask

    initial begin
        repeat (2) @(negedge clock);
        check_reset_vals("reset_vals");
        reset = 1'b0;
        @(negedge clock);
        check_reset_vals("idle_vals");

        run_cmd(6'd0, 32'h0, 1, 8'h01, 0, 0);
        run_cmd(6'd8, 32'h000001AA, 0, 8'h01, 0, 0);
        run_cmd(6'd55, 32'h0, -1, 8'h00, 0, 0);
        run_cmd(6'd17, 32'h00001200, 3, 8'h00, 0, 1);
        run_cmd(6'd0, 32'h0, 0, 8'h01, 60, 0);
        run_cmd(6'd41, 32'h40000000, NCR - 1, 8'h05, 3, 0);

        reset_mid(6'd17, 32'h00000200);
        run_cmd(6'd0, 32'h0, 1, 8'h01, 0, 0);

        for (int t = 0; t < 10; t++) begin
            int ra;
            ra = int'($urandom_range(0, NCR + 1)) - 1;
            run_cmd(6'($urandom), $urandom, ra, 8'($urandom) & 8'h7F,
                    int'($urandom_range(0, 5)), bit'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
